fb_write_arbiter: RTL

Shares the single on-chip frame-buffer write port between up to N_REQ burst writers: blue trail, red trail, score/text overlay and spare. Contains a built-in clear engine that fills the play-field region with a background value at round start. Burst-locked round-robin grant. One registered write per cycle to the frame buffer.

---
 rtl/fb_write_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter
// Purpose  : Shares the single frame-buffer write port between N_REQ burst
//            writers using a burst-locked round-robin grant, and includes a
//            clear engine that fills a region with a constant value. The
//            clear engine takes priority over all requesters. Exactly one
//            registered write per cycle goes to the frame buffer.
// Ports    : Clk, Reset        - clock, synchronous active-high reset
//            req_valid/last    - per-requester beat valid / final beat
//            req_addr/data     - packed, requester i at [i*W +: W]
//            req_ready         - one-hot (or zero) beat accept
//            clear_start       - one-cycle clear request pulse
//            clear_busy        - clear pending or running
//            vblank            - vertical blanking (gating option only)
//            fb_addr/data/we   - registered frame-buffer write port
//            grant_id          - current grant holder index (valid in GRANT)
// Options  : FB_VBLANK_GATE_EN - when defined, IDLE starts a grant or a
//            clear only while vblank=1.
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
  parameter int                N_REQ       = 4,
  parameter int                ADDR_W      = 20,
  parameter int                DATA_W      = 16,
  parameter int                MAX_BURST   = 64,
  parameter logic [ADDR_W-1:0] CLEAR_BASE  = '0,
  parameter int                CLEAR_LEN   = 153600,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    clear_start,
  output logic                    clear_busy,
  input  logic                    vblank,
  output logic [ADDR_W-1:0]       fb_addr,
  output logic [DATA_W-1:0]       fb_data,
  output logic                    fb_we,
  output logic [2:0]              grant_id
);

  localparam int c_IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [c_BW-1:0]   c_BEAT_LAST  = c_BW'(MAX_BURST - 1);
  localparam logic [ADDR_W-1:0] c_CLEAR_LAST = CLEAR_BASE + ADDR_W'(CLEAR_LEN - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_GRANT = 2'd1;
  localparam logic [1:0] c_ST_CLEAR = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [c_IW-1:0]   r_rr_ptr;
  logic [c_IW-1:0]   r_grant;
  logic [c_BW-1:0]   r_beat_cnt;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic              r_clear_pending;

  logic              w_gate_ok;
  logic              w_found;
  logic [c_IW-1:0]   w_pick;
  logic              w_beat;
  logic              w_release;
  logic              w_clear_done;
  logic [c_IW-1:0]   w_rr_next;

  logic [ADDR_W-1:0] w_addr_arr [N_REQ];
  logic [DATA_W-1:0] w_data_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef FB_VBLANK_GATE_EN
  assign w_gate_ok = vblank;
`else
  // vblank has no influence on arbitration in this build.
  assign w_gate_ok = vblank | 1'b1;
`endif

  // Round-robin pick: scan downward so the lowest offset from r_rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[c_IW'((int'(r_rr_ptr) + k) % N_REQ)]) begin
        w_found = 1'b1;
        w_pick  = c_IW'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  // req_ready[g] is always 1 in GRANT, so valid alone qualifies a beat.
  assign w_beat       = (r_state == c_ST_GRANT) && req_valid[r_grant];
  assign w_release    = w_beat && (req_last[r_grant] || (r_beat_cnt == c_BEAT_LAST));
  assign w_clear_done = (r_state == c_ST_CLEAR) && (r_addr_cnt == c_CLEAR_LAST);
  assign w_rr_next    = c_IW'((int'(r_grant) + 1) % N_REQ);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_gate_ok) begin
          if (r_clear_pending) w_state_nxt = c_ST_CLEAR;
          else if (w_found)    w_state_nxt = c_ST_GRANT;
        end
      end
      c_ST_GRANT: if (w_release)    w_state_nxt = c_ST_IDLE;
      c_ST_CLEAR: if (w_clear_done) w_state_nxt = c_ST_IDLE;
      default:                      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (r_state == c_ST_GRANT) req_ready[r_grant] = 1'b1;
    clear_busy = r_clear_pending | (r_state == c_ST_CLEAR);
  end

  assign grant_id = 3'(r_grant);

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rr_ptr        <= '0;
      r_grant         <= '0;
      r_beat_cnt      <= '0;
      r_addr_cnt      <= '0;
      r_clear_pending <= 1'b0;
      fb_we           <= 1'b0;
      fb_addr         <= '0;
      fb_data         <= '0;
    end else begin
      fb_we <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_gate_ok && r_clear_pending) begin
            r_addr_cnt <= CLEAR_BASE;
          end else if (w_gate_ok && w_found) begin
            r_grant    <= w_pick;
            r_beat_cnt <= '0;
          end
        end
        c_ST_GRANT: begin
          if (w_beat) begin
            fb_we      <= 1'b1;
            fb_addr    <= w_addr_arr[r_grant];
            fb_data    <= w_data_arr[r_grant];
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
          if (w_release) r_rr_ptr <= w_rr_next;
        end
        c_ST_CLEAR: begin
          fb_we      <= 1'b1;
          fb_addr    <= r_addr_cnt;
          fb_data    <= CLEAR_VALUE;
          r_addr_cnt <= r_addr_cnt + 1'b1;
        end
        default: ;
      endcase

      // Pending is consumed on CLEAR entry; pulses during CLEAR are dropped,
      // pulses while already pending collapse into the one pending clear.
      if ((r_state == c_ST_IDLE) && w_gate_ok && r_clear_pending)
        r_clear_pending <= 1'b0;
      else if (clear_start && (r_state != c_ST_CLEAR))
        r_clear_pending <= 1'b1;
    end
  end

endmodule
`default_nettype wire
